// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared widths and FSM state encoding for mem_dump
package mem_dump_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        PULSE = 3'd2,
        VALID = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// rtl/mem_dump_if.sv - memory read port and output byte stream of mem_dump
interface mem_dump_if;
    import mem_dump_pkg::*;

    logic              mem_clock;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_clock, mem_write, mem_addr, out_data, out_valid,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_clock, mem_write, mem_addr, out_data, out_valid,
        output mem_data, out_ready
    );

endinterface

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - reads an inclusive, wrapping address range from memory
// and streams each byte out with a valid/ready handshake.
module mem_dump
    import mem_dump_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    mem_dump_if.master        bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mem_clock_q, mem_clock_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            data_q      <= '0;
            mem_clock_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            data_q      <= data_d;
            mem_clock_q <= mem_clock_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    // Registered outputs are computed for the state being entered, so the
    // strobe is high exactly while in PULSE and done exactly while in DONE.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        data_d      = data_q;
        mem_clock_d = 1'b0;
        valid_d     = valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = first_addr;
                    last_d  = last_addr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                mem_clock_d = 1'b1;
                state_d     = PULSE;
            end
            PULSE: begin
                data_d  = bus.mem_data;
                valid_d = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_clock = mem_clock_q;
    assign bus.mem_write = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - scoreboard bench for mem_dump: expected bytes queued
// from a memory model at start, popped on each observed handshake.
module tb_mem_dump;
    import mem_dump_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] exp_q [$];
    int                hs_cyc [$];

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int hs_count     = 0;
    int done_count   = 0;
    int mem_write_hi = 0;

    mem_dump_if bus();

    mem_dump dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    always #5 clock = ~clock;

    // Memory model: captures the address on the rising edge of the strobe.
    always @(posedge bus.mem_clock) bus.mem_data <= mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor sits 2 time units after the falling edge, once inputs driven there have settled.
    always begin
        @(negedge clock);
        #2;
        cyc++;
        if (bus.mem_write !== 1'b0) mem_write_hi++;
        if (done === 1'b1) done_count++;
        if (reset !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hs_count++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
            else check("byte", bus.out_data, exp_q.pop_front());
        end
    end

    task automatic run_dump(input logic [7:0] f, input logic [7:0] l, output int lat, output int span);
        int         n;
        int         k;
        int         d0;
        logic [7:0] a;
        n = int'(8'(l - f)) + 1;
        a = f;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[a]);
            a = a + 8'd1;
        end
        d0 = done_count;
        lat = 0;
        span = 0;
        k = 0;
        first_addr = f;
        last_addr = l;
        start = 1'b1;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) start = 1'b0;
            if (lat == 0 && bus.out_valid === 1'b1) lat = k;
            if (busy === 1'b1) span = k + 1;
        end while ((busy === 1'b1 || k < 2) && k < 1200);
        check("dump_timeout", busy, 0);
        @(negedge clock);
        check("done_pulses", done_count - d0, 1);
        check("drained", exp_q.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_memclk"}, bus.mem_clock, 0);
        check({tag, "_memwr"}, bus.mem_write, 0);
    endtask

    initial begin
        int               lat;
        int               span;
        int               h0;
        int               d0;
        int               g;
        logic [DATA_W-1:0] held;

        reset = 1'b1;
        start = 1'b0;
        first_addr = '0;
        last_addr = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'h10 + 8'(i);
        mem[8'h05] = 8'hA5;

        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Four bytes, one every three cycles
        hs_cyc.delete();
        run_dump(8'h20, 8'h23, lat, span);
        check("latency", lat, 3);
        check("count_4", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("spacing", hs_cyc[i] - hs_cyc[i-1], 3);

        // Single byte: start cycle through DONE spans five cycles
        h0 = hs_count;
        run_dump(8'h05, 8'h05, lat, span);
        check("single_count", hs_count - h0, 1);
        check("single_busy_span", span, 5);

        // Wrap across 0xFF
        h0 = hs_count;
        run_dump(8'hFE, 8'h01, lat, span);
        check("wrap_count", hs_count - h0, 4);

        // first == last + 1 dumps the whole memory
        h0 = hs_count;
        run_dump(8'h40, 8'h3F, lat, span);
        check("full_count", hs_count - h0, 256);

        // Consumer stalls for 10 cycles on the second byte
        h0 = hs_count;
        fork
            run_dump(8'h60, 8'h63, lat, span);
            begin
                g = 0;
                while (hs_count < h0 + 1 && g < 50) begin @(negedge clock); g++; end
                bus.out_ready = 1'b0;
                while (bus.out_valid !== 1'b1 && g < 50) begin @(negedge clock); g++; end
                check("stall_wait", g < 50, 1);
                held = bus.out_data;
                check("stall_byte", held, mem[8'h61]);
                for (int i = 0; i < 10; i++) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, mem[8'h61]);
                    check("stall_memclk", bus.mem_clock, 0);
                    if (i < 9) @(negedge clock);
                end
                bus.out_ready = 1'b1;
            end
        join
        check("stall_count", hs_count - h0, 4);

        // Reset while the third byte of an 8-byte dump is waiting
        h0 = hs_count;
        d0 = done_count;
        for (int i = 0; i < 8; i++) exp_q.push_back(mem[8'h70 + i]);
        first_addr = 8'h70;
        last_addr = 8'h77;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        g = 0;
        while (hs_count < h0 + 2 && g < 50) begin @(negedge clock); g++; end
        while (bus.out_valid !== 1'b1 && g < 50) begin @(negedge clock); g++; end
        check("third_valid", bus.out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        check_idle_zero("midreset");
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("no_done_after_reset", done_count - d0, 0);
        check("idle_after_reset", busy, 0);
        h0 = hs_count;
        run_dump(8'h70, 8'h72, lat, span);
        check("after_reset_count", hs_count - h0, 3);
        check("after_reset_latency", lat, 3);

        // A second start during a dump is ignored
        h0 = hs_count;
        fork
            run_dump(8'h30, 8'h35, lat, span);
            begin
                repeat (4) @(negedge clock);
                first_addr = 8'h80;
                last_addr = 8'h90;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        join
        check("ignored_start_count", hs_count - h0, 6);
        repeat (3) @(negedge clock);
        check("ignored_start_idle", busy, 0);
        check("mem_write_low", mem_write_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
